// File: rtl/evt_arb_pkg.sv
// Shared types and the round-robin pick helper for the clocked-to-self-timed event port arbiter.
package evt_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        REQ   = 2'd2,
        REL   = 2'd3
    } arb_state_e;

    localparam int MAX_REQ = 16;

    // First set bit of valid at or after ptr, wrapping at n; returns ptr when nothing is set.
    function automatic logic [3:0] rr_pick(input logic [MAX_REQ-1:0] valid,
                                           input logic [3:0]         ptr,
                                           input int                 n);
        logic found;
        int   j;
        rr_pick = ptr;
        found   = 1'b0;
        for (int k = 0; k < MAX_REQ; k++) begin
            if (k < n) begin
                j = int'(ptr) + k;
                if (j >= n) j = j - n;
                if (!found && valid[j[3:0]]) begin
                    rr_pick = j[3:0];
                    found   = 1'b1;
                end
            end
        end
    endfunction

endpackage

// File: rtl/evt_port_arbiter_if.sv
// Requester bus plus the 4-phase bundled-data link to the first event register.
interface evt_port_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 8
);
    logic [N_REQ-1:0]         req_valid;
    logic [N_REQ*WIDTH-1:0]   req_data;
    logic [N_REQ-1:0]         req_ready;
    logic [WIDTH-1:0]         data_out;
    logic                     rin;
    logic                     ain;
    logic [$clog2(N_REQ)-1:0] gnt_id;
    logic                     busy;
    logic                     err;

    // The arbiter masters the handshake towards the event register.
    modport master (
        input  req_valid, req_data, ain,
        output req_ready, data_out, rin, gnt_id, busy, err
    );

    modport slave (
        output req_valid, req_data, ain,
        input  req_ready, data_out, rin, gnt_id, busy, err
    );
endinterface

// File: rtl/evt_sync.sv
// Multi-flop synchronizer for a single asynchronous level; resets to 0.
module evt_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);
    logic [SYNC_STAGES-1:0] chain;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) chain <= '0;
        else        chain <= {chain[SYNC_STAGES-2:0], d};
    end

    assign q = chain[SYNC_STAGES-1];
endmodule

// File: rtl/evt_port_arbiter.sv
// Round-robin arbiter feeding one event register over a 4-phase rin/ain handshake.
// Optional watchdog compiled in with EVT_ARB_TIMEOUT_EN.
module evt_port_arbiter
    import evt_arb_pkg::*;
#(
    parameter int N_REQ       = 4,
    parameter int WIDTH       = 8,
    parameter int SETUP_CYC   = 2,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 255
) (
    input  logic               clk,
    input  logic               rst_n,
    evt_port_arbiter_if.master bus
);
    localparam int IDX_W = $clog2(N_REQ);
    localparam int SU_W  = $clog2(SETUP_CYC + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_REQ - 1);
    localparam logic [SU_W-1:0]  SU_LAST  = SU_W'(SETUP_CYC - 1);

    arb_state_e       state_q, state_d;
    logic             rin_q, rin_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [IDX_W-1:0] gnt_q, gnt_d;
    logic [IDX_W-1:0] rr_q, rr_d;
    logic [N_REQ-1:0] rdy_q, rdy_d;
    logic [SU_W-1:0]  su_q, su_d;
    logic [IDX_W-1:0] pick;
    logic             ack_s;

`ifdef EVT_ARB_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);
    logic [WD_W-1:0] wd_q, wd_d;
    logic            err_q, err_d;
`endif

    evt_sync #(.SYNC_STAGES(SYNC_STAGES)) u_ack_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (bus.ain),
        .q     (ack_s)
    );

    assign pick = IDX_W'(rr_pick(MAX_REQ'(bus.req_valid), 4'(rr_q), N_REQ));

    always_comb begin
        state_d = state_q;
        rin_d   = rin_q;
        data_d  = data_q;
        gnt_d   = gnt_q;
        rr_d    = rr_q;
        rdy_d   = '0;
        su_d    = su_q;
`ifdef EVT_ARB_TIMEOUT_EN
        wd_d    = wd_q;
        err_d   = err_q;
`endif
        case (state_q)
            IDLE: begin
                // A stale ack from the previous cycle blocks the next grant.
                if (|bus.req_valid && !ack_s) begin
                    gnt_d   = pick;
                    data_d  = bus.req_data[pick*WIDTH +: WIDTH];
                    su_d    = '0;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                if (su_q == SU_LAST) begin
                    rin_d   = 1'b1;
                    state_d = REQ;
                end else begin
                    su_d = su_q + 1'b1;
                end
            end
            REQ: begin
                if (ack_s) begin
                    rdy_d[gnt_q] = 1'b1;
                    rin_d        = 1'b0;
                    rr_d         = (gnt_q == LAST_IDX) ? '0 : gnt_q + 1'b1;
                    state_d      = REL;
                end
            end
            REL: begin
                if (!ack_s) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
`ifdef EVT_ARB_TIMEOUT_EN
        // Watchdog restarts on every state change and saturates in REL.
        if (state_d != state_q) begin
            wd_d = '0;
        end else if (state_q == REQ || state_q == REL) begin
            if (wd_q == WD_LAST) begin
                err_d = 1'b1;
                if (state_q == REQ) begin
                    rin_d   = 1'b0;
                    state_d = REL;
                    wd_d    = '0;
                end
            end else begin
                wd_d = wd_q + 1'b1;
            end
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rin_q   <= 1'b0;
            data_q  <= '0;
            gnt_q   <= '0;
            rr_q    <= '0;
            rdy_q   <= '0;
            su_q    <= '0;
        end else begin
            state_q <= state_d;
            rin_q   <= rin_d;
            data_q  <= data_d;
            gnt_q   <= gnt_d;
            rr_q    <= rr_d;
            rdy_q   <= rdy_d;
            su_q    <= su_d;
        end
    end

`ifdef EVT_ARB_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_q  <= '0;
            err_q <= 1'b0;
        end else begin
            wd_q  <= wd_d;
            err_q <= err_d;
        end
    end

    assign bus.err = err_q;
`else
    // Watchdog compiled out: err is constant 0 for any legal TIMEOUT.
    assign bus.err = (TIMEOUT < 0);
`endif

    assign bus.rin       = rin_q;
    assign bus.data_out  = data_q;
    assign bus.gnt_id    = gnt_q;
    assign bus.req_ready = rdy_q;
    assign bus.busy      = (state_q != IDLE);
endmodule

// File: tb/tb_evt_port_arbiter.sv
// Randomized bench for evt_port_arbiter with an event-register model and a round-robin reference.
`timescale 1ns/1ps
module tb_evt_port_arbiter;
    localparam int N  = 4;
    localparam int W  = 8;
    localparam int SU = 2;
    localparam int SS = 2;
    localparam int TO = 20;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    evt_port_arbiter_if #(.N_REQ(N), .WIDTH(W)) bus ();

    evt_port_arbiter #(
        .N_REQ(N), .WIDTH(W), .SETUP_CYC(SU), .SYNC_STAGES(SS), .TIMEOUT(TO)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Requester side
    logic [N-1:0] hold_mask  = '0;
    logic [N-1:0] pulse_mask = '0;
    logic [W-1:0] words [N];

    always_comb begin
        bus.req_data = '0;
        for (int i = 0; i < N; i++) bus.req_data[i*W +: W] = words[i];
        bus.req_valid = hold_mask | pulse_mask;
    end

    // Event register: ain follows rin after 1-7 ns unless stuck
    bit stuck = 1'b0;
    initial begin
        bus.ain = 1'b0;
        forever begin
            @(bus.rin);
            #($urandom_range(7, 1));
            if (!stuck) bus.ain = bus.rin;
        end
    end

    // Reference: strict round robin over the requesters holding valid
    int       model_rr = 0;
    int       exp_rdy  = -1;
    bit       cap_en   = 1'b1;
    bit       no_gnt1  = 1'b0;
    int       grant_cnt [N];
    int       seq [$];
    int       cap_w;
    logic [W-1:0] cap_word = '0;

    function automatic int ref_pick(input logic [N-1:0] m, input int rr);
        for (int k = 0; k < N; k++)
            if (m[(rr + k) % N]) return (rr + k) % N;
        return -1;
    endfunction

    always @(posedge bus.ain) begin
        if (cap_en && rst_n) begin
            cap_w    = ref_pick(hold_mask, model_rr);
            cap_word = bus.data_out;
            chk_eq("cap_gnt", 32'(bus.gnt_id), cap_w);
            if (cap_w >= 0) begin
                chk_eq("cap_data", 32'(bus.data_out), 32'(words[cap_w]));
                model_rr = (cap_w + 1) % N;
            end
            exp_rdy = cap_w;
        end
    end

    always @(negedge clk) begin
        if (rst_n && cap_en) begin
            if (bus.req_ready != '0) begin
                chk_eq("ready_mask", 32'(bus.req_ready), (exp_rdy >= 0) ? (32'd1 << exp_rdy) : 32'd0);
                if (exp_rdy >= 0) begin
                    grant_cnt[exp_rdy]++;
                    seq.push_back(exp_rdy);
                end
                exp_rdy = -1;
            end
            if (no_gnt1) chk_eq("withdraw_gnt_id", 32'(bus.gnt_id == 1), 0);
        end
    end

    task automatic do_reset();
        cap_en = 1'b0;
        rst_n  = 1'b0;
        repeat (3) @(negedge clk);
        rst_n    = 1'b1;
        model_rr = 0;
        exp_rdy  = -1;
        cap_en   = 1'b1;
    endtask

    task automatic wait_grants(input int target, input int budget, input string tag);
        int n = 0;
        while (seq.size() < target && n < budget) begin
            @(negedge clk); #1;
            n++;
        end
        chk_eq(tag, seq.size(), target);
    endtask

    task automatic wait_rin(input logic val, input int budget, input string tag);
        int n = 0;
        while (bus.rin !== val && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        chk_eq(tag, 32'(bus.rin), 32'(val));
    endtask

    task automatic wait_idle(input int budget, input string tag);
        int n = 0;
        while (bus.busy !== 1'b0 && n < budget) begin
            @(negedge clk); #1;
            n++;
        end
        chk_eq(tag, 32'(bus.busy), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk_eq({tag, "_rin"},   32'(bus.rin), 0);
        chk_eq({tag, "_data"},  32'(bus.data_out), 0);
        chk_eq({tag, "_ready"}, 32'(bus.req_ready), 0);
        chk_eq({tag, "_gnt"},   32'(bus.gnt_id), 0);
        chk_eq({tag, "_busy"},  32'(bus.busy), 0);
        chk_eq({tag, "_err"},   32'(bus.err), 0);
    endtask

    initial begin
        int n;
        int base, c0, c3;
        for (int i = 0; i < N; i++) begin
            words[i]     = W'($urandom);
            grant_cnt[i] = 0;
        end

        // Reset state
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        do_reset();

        // 1: single request, latency and capture
        @(negedge clk);
        words[2]  = 8'hA5;
        hold_mask = 4'b0100;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (bus.rin !== 1'b1 && n < 20);
        chk_eq("t1_rin_latency", n, SU + 1);
        wait_grants(1, 50, "t1_grant");
        chk_eq("t1_winner", seq[0], 2);
        chk_eq("t1_word", 32'(cap_word), 32'h A5);
        hold_mask = '0;
        wait_idle(50, "t1_busy");

        // 2: contention from rr=0 with random wait before start
        do_reset();
        for (int i = 0; i < N; i++) words[i] = W'(8'h10 + i);
        repeat ($urandom_range(3, 0)) @(negedge clk);
        base = seq.size();
        hold_mask = 4'b1111;
        wait_grants(base + 5, 200, "t2_grants");
        hold_mask = '0;
        for (int i = 0; i < 5; i++) chk_eq("t2_order", seq[base + i], i % N);
        wait_idle(50, "t2_busy");

        // 3: wrap and fairness between 3 and 0
        base = seq.size();
        words[3]  = W'($urandom);
        hold_mask = 4'b1000;
        wait_grants(base + 1, 100, "t3_first");
        chk_eq("t3_first_winner", seq[base], 3);
        c0 = grant_cnt[0];
        c3 = grant_cnt[3];
        hold_mask = 4'b1001;
        for (int r = 0; r < 200; r++) begin
            wait_grants(base + 2 + r, 100, "t3_grant");
            if (r % 20 == 0) begin
                words[0] = W'($urandom);
                words[3] = W'($urandom);
            end
        end
        hold_mask = '0;
        chk_eq("t3_next_after_3", seq[base + 1], 0);
        chk_eq("t3_count0", grant_cnt[0] - c0, 100);
        chk_eq("t3_count3", grant_cnt[3] - c3, 100);
        wait_idle(50, "t3_busy");

        // 4: requester 1 withdraws while 0 is in REQ
        base = seq.size();
        no_gnt1  = 1'b1;
        words[0] = W'($urandom);
        hold_mask = 4'b0001;
        wait_rin(1'b1, 50, "t4_rin");
        pulse_mask = 4'b0010;
        @(posedge clk); #1;
        pulse_mask = '0;
        wait_grants(base + 1, 50, "t4_grant");
        hold_mask = '0;
        repeat (20) @(negedge clk);
        chk_eq("t4_no_extra", seq.size(), base + 1);
        chk_eq("t4_winner", seq[base], 0);
        no_gnt1 = 1'b0;
        wait_idle(50, "t4_busy");

        // 5: asynchronous reset mid-REQ
        words[2]  = 8'h5C;
        hold_mask = 4'b0100;
        wait_rin(1'b1, 50, "t5_rin");
        cap_en = 1'b0;
        rst_n  = 1'b0;
        #1;
        check_reset_outputs("t5_async");
        #30;
        @(negedge clk);
        rst_n    = 1'b1;
        model_rr = 0;
        exp_rdy  = -1;
        cap_en   = 1'b1;
        base = seq.size();
        wait_grants(base + 1, 50, "t5_after");
        chk_eq("t5_winner", seq[base], 2);
        chk_eq("t5_word", 32'(cap_word), 32'h5C);
        hold_mask = '0;
        wait_idle(50, "t5_busy");

`ifdef EVT_ARB_TIMEOUT_EN
        // 6: watchdog with ain stuck low
        base = seq.size();
        stuck     = 1'b1;
        words[1]  = 8'h77;
        hold_mask = 4'b0010;
        wait_rin(1'b1, 50, "t6_rin_rise");
        n = 0;
        while (bus.rin === 1'b1 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        hold_mask = '0;
        chk_eq("t6_rin_cycles", n, TO);
        chk_eq("t6_err", 32'(bus.err), 1);
        repeat (10) @(negedge clk);
        chk_eq("t6_no_ready", seq.size(), base);
        stuck = 1'b0;
        wait_idle(50, "t6_busy");
        hold_mask = 4'b0010;
        wait_grants(base + 1, 50, "t6_good");
        hold_mask = '0;
        wait_idle(50, "t6_busy2");
        chk_eq("t6_err_sticky", 32'(bus.err), 1);
`else
        chk_eq("err_tied_low", 32'(bus.err), 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
